// File: rtl/fifo_wr_arbiter_if.sv
// Requester-stream and fifo-write-port bundle for the round-robin write arbiter.
// The arbiter connects as master; the requester/fifo environment connects as slave.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 4
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]       fifo_data_o;
  logic                        fifo_push_o;
  logic                        fifo_full_i;
  logic [N_REQ-1:0]            grant_o;
  logic                        busy_o;

  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_data_o, fifo_push_o, grant_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_data_o, fifo_push_o, grant_o, busy_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ valid/ready requesters,
// granting one requester at a time for a burst of at most MAX_BURST pushes.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_wr_arbiter_if.master    bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [N_REQ-1:0]      ready_c;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic                  found_c;
  logic [IDX_W-1:0]      sel_c;

  // last_q doubles as the granted index while in BURST
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Rotating priority search starting just after the last granted index
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!found_c && bus.req_valid_i[(int'(last_q) + i) % N_REQ]) begin
        found_c = 1'b1;
        sel_c   = IDX_W'((int'(last_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d    = BURST;
          grant_d    = N_REQ'(1) << sel_c;
          last_d     = sel_c;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (!bus.req_valid_i[last_q] ||
            (push_c && beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
        end else if (push_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Same-cycle handshake; rst_i gates push/ready so no beat lands during reset
  always_comb begin
    ready_c = '0;
    push_c  = 1'b0;
    data_c  = '0;
    if (state_q == BURST && !rst_i) begin
      ready_c[last_q] = ~bus.fifo_full_i;
      push_c          = bus.req_valid_i[last_q] & ~bus.fifo_full_i;
      data_c          = bus.req_data_i[int'(last_q) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.fifo_push_o = push_c;
  assign bus.fifo_data_o = data_c;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = (state_q == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=4, MAX_BURST=4).
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   p0;

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_WIDTH(4)) bus ();

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(4), .MAX_BURST(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.fifo_push_o === 1'b1) pushes++;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(bus.grant_o), 32'h0);
    check({tag, "_busy"},  32'(bus.busy_o), 32'h0);
    check({tag, "_push"},  32'(bus.fifo_push_o), 32'h0);
    check({tag, "_ready"}, 32'(bus.req_ready_o), 32'h0);
    check({tag, "_data"},  32'(bus.fifo_data_o), 32'h0);
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.fifo_full_i = 1'b0;

    // 1: reset with random inputs, then first grant goes to requester 0
    #2;
    rst = 1'b1;
    bus.req_valid_i = 4'($urandom);
    bus.req_data_i  = 16'($urandom);
    bus.fifo_full_i = 1'($urandom);
    #1;
    check_idle("t1_rst");
    tick();
    tick();
    rst = 1'b0;
    bus.req_valid_i = 4'b0001;
    bus.req_data_i  = 16'h0005;
    bus.fifo_full_i = 1'b0;
    #1;
    check("t1_grant_pre", 32'(bus.grant_o), 32'h0);
    tick();
    check("t1_grant", 32'(bus.grant_o), 32'h1);
    check("t1_push", 32'(bus.fifo_push_o), 32'h1);
    check("t1_data", 32'(bus.fifo_data_o), 32'h5);
    bus.req_valid_i = 4'b0000;
    #1;
    check("t1_push_drop", 32'(bus.fifo_push_o), 32'h0);
    tick();
    check_idle("t1_rel");

    // 2: short burst from requester 2 (A, B), release on valid drop
    bus.req_valid_i = 4'b0100;
    bus.req_data_i  = 16'h0A00;
    p0 = pushes;
    tick();
    check("t2_grant", 32'(bus.grant_o), 32'h4);
    check("t2_ready", 32'(bus.req_ready_o), 32'h4);
    check("t2_push_a", 32'(bus.fifo_push_o), 32'h1);
    check("t2_data_a", 32'(bus.fifo_data_o), 32'hA);
    tick();
    bus.req_data_i = 16'h0B00;
    #1;
    check("t2_push_b", 32'(bus.fifo_push_o), 32'h1);
    check("t2_data_b", 32'(bus.fifo_data_o), 32'hB);
    tick();
    bus.req_valid_i = 4'b0000;
    #1;
    check("t2_push_end", 32'(bus.fifo_push_o), 32'h0);
    check("t2_busy_end", 32'(bus.busy_o), 32'h1);
    tick();
    check("t2_busy_rel", 32'(bus.busy_o), 32'h0);
    check("t2_npush", 32'(pushes - p0), 32'd2);

    // 3: full contention after a fresh reset: grants 0,1,2,3,0 in 25 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.req_data_i  = 16'h4321;
    #1;
    p0 = pushes;
    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0) begin
        check("t3_bubble", 32'(bus.grant_o), 32'h0);
      end else begin
        check("t3_grant", 32'(bus.grant_o), 32'(4'b0001 << ((i / 5) % 4)));
        check("t3_data", 32'(bus.fifo_data_o), 32'((i / 5) % 4 + 1));
      end
      tick();
    end
    bus.req_valid_i = 4'b0000;
    check("t3_npush", 32'(pushes - p0), 32'd20);
    check("t3_rel", 32'(bus.grant_o), 32'h0);
    tick();

    // 4: full stall on requester 1 after its first push
    bus.req_valid_i = 4'b0010;
    bus.req_data_i  = 16'h0070;
    p0 = pushes;
    tick();
    check("t4_grant", 32'(bus.grant_o), 32'h2);
    check("t4_push1", 32'(bus.fifo_push_o), 32'h1);
    tick();
    bus.fifo_full_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_push", 32'(bus.fifo_push_o), 32'h0);
      check("t4_stall_ready", 32'(bus.req_ready_o), 32'h0);
      check("t4_stall_grant", 32'(bus.grant_o), 32'h2);
      tick();
    end
    bus.fifo_full_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t4_push", 32'(bus.fifo_push_o), 32'h1);
      check("t4_data", 32'(bus.fifo_data_o), 32'h7);
      tick();
    end
    check("t4_rel", 32'(bus.grant_o), 32'h0);
    check("t4_npush", 32'(pushes - p0), 32'd4);

    // 5: after index 1, valid 1001 picks 3, then 0
    bus.req_valid_i = 4'b1001;
    tick();
    check("t5_grant3", 32'(bus.grant_o), 32'h8);
    bus.req_valid_i = 4'b0001;
    tick();
    check("t5_bubble", 32'(bus.grant_o), 32'h0);
    check("t5_bubble_busy", 32'(bus.busy_o), 32'h0);
    tick();
    check("t5_grant0", 32'(bus.grant_o), 32'h1);
    bus.req_valid_i = 4'b0000;
    tick();

    // 6: async reset during the second beat of requester 2
    bus.req_valid_i = 4'b0100;
    bus.req_data_i  = 16'h0C00;
    tick();
    check("t6_grant", 32'(bus.grant_o), 32'h4);
    tick();
    p0 = pushes;
    #1;
    check("t6_push2_pre", 32'(bus.fifo_push_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_idle("t6_rst");
    tick();
    check("t6_npush", 32'(pushes - p0), 32'd0);
    rst = 1'b0;
    bus.req_valid_i = 4'b0101;
    #1;
    check("t6_idle", 32'(bus.busy_o), 32'h0);
    tick();
    check("t6_regrant", 32'(bus.grant_o), 32'h1);
    bus.req_valid_i = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
